instr_issue_queue: RTL and testbench

INSTR_ISSUE_QUEUE -- requirements
Module: instr_issue_queue

---
 rtl/arm_pkg.sv | 40 ++++
 rtl/instr_issue_queue_if.sv | 29 ++
 rtl/instr_fifo.sv | 70 +++++++
 rtl/instr_issue_queue.sv | 116 +++++++++++
 tb/tb_instr_issue_queue.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/arm_pkg.sv
// Shared encodings for the ARM-style front end: NOP word, issue pacing default,
// issue-queue FSM state codes and data-processing opcode / CPSR flag positions.
package arm_pkg;

   localparam logic [31:0] NOP             = 32'h0000_0000;
   localparam int          NOP_GAP_DEFAULT = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_GAP   = 2'd2
   } issue_state_e;

   localparam logic [1:0] ST_IDLE  = S_IDLE;
   localparam logic [1:0] ST_ISSUE = S_ISSUE;
   localparam logic [1:0] ST_GAP   = S_GAP;

   localparam logic [3:0] OP_AND = 4'h0;
   localparam logic [3:0] OP_EOR = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_RSB = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_ADC = 4'h5;
   localparam logic [3:0] OP_SBC = 4'h6;
   localparam logic [3:0] OP_RSC = 4'h7;
   localparam logic [3:0] OP_TST = 4'h8;
   localparam logic [3:0] OP_TEQ = 4'h9;
   localparam logic [3:0] OP_CMP = 4'hA;
   localparam logic [3:0] OP_CMN = 4'hB;
   localparam logic [3:0] OP_ORR = 4'hC;
   localparam logic [3:0] OP_MOV = 4'hD;
   localparam logic [3:0] OP_BIC = 4'hE;
   localparam logic [3:0] OP_MVN = 4'hF;

   localparam int F_N = 31;
   localparam int F_Z = 30;
   localparam int F_C = 29;
   localparam int F_V = 28;

endpackage

// File: rtl/instr_issue_queue_if.sv
// Loader/core side of the issue queue: push handshake, stall/flush controls
// and the registered issue stream with FIFO occupancy.
interface instr_issue_queue_if #(
   parameter int DEPTH = 8
);
   localparam int CW = $clog2(DEPTH + 1);

   logic          in_valid;
   logic [31:0]   in_instr;
   logic          in_ready;
   logic          stall;
   logic          flush;
   logic [31:0]   Instruction;
   logic          issued;
   logic [CW-1:0] count;
   logic          empty;
   logic          full;

   modport master (
      output in_valid, in_instr, stall, flush,
      input  in_ready, Instruction, issued, count, empty, full
   );

   modport slave (
      input  in_valid, in_instr, stall, flush,
      output in_ready, Instruction, issued, count, empty, full
   );

endinterface

// File: rtl/instr_fifo.sv
// DEPTH x 32 instruction FIFO with synchronous flush; head word is visible
// combinationally so the issue FSM can load it on the popping edge.
module instr_fifo
   import arm_pkg::*;
#(
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [31:0]   push_data,
   input  logic          pop,
   input  logic          flush,
   output logic [31:0]   head,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic          full
);

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          wr_en;
   logic          rd_en;

   assign wr_en = push && !full && !flush;
   assign rd_en = pop && !empty && !flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so pointer overflow is the modulo wrap
         if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
         if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
         if (wr_en && !rd_en)      count_d = count_q + CW'(1);
         else if (rd_en && !wr_en) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= push_data;
   end

   assign head  = mem[rd_ptr_q];
   assign count = count_q;
   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/instr_issue_queue.sv
// Paces queued instructions onto the core fetch input, inserting NOP_GAP NOPs
// after every real word; stall freezes the stream, flush drops everything.
//
// state    | meaning
// ST_IDLE  | nothing in flight, NOP on Instruction, waiting for a queued word
// ST_ISSUE | real word on Instruction for one unstalled cycle, issued=1
// ST_GAP   | NOP padding, gap counter counts down to zero
module instr_issue_queue
   import arm_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int NOP_GAP = NOP_GAP_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   instr_issue_queue_if.slave q
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int GW = (NOP_GAP > 0) ? $clog2(NOP_GAP + 1) : 1;
   localparam logic [GW-1:0] GAP_LOAD = GW'((NOP_GAP > 0) ? NOP_GAP - 1 : 0);

   logic [1:0]    state_q, state_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [31:0]   instr_q, instr_d;
   logic          try_issue;
   logic          pop;
   logic          push;
   logic [31:0]   head;
   logic [CW-1:0] fifo_count;
   logic          fifo_empty;
   logic          fifo_full;

   assign q.in_ready = !fifo_full && !q.flush;
   assign push       = q.in_valid && q.in_ready;

   instr_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (q.in_instr),
      .pop       (pop),
      .flush     (q.flush),
      .head      (head),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   always_comb begin
      state_d   = state_q;
      gap_d     = gap_q;
      instr_d   = instr_q;
      try_issue = 1'b0;
      pop       = 1'b0;
      if (q.flush) begin
         state_d = ST_IDLE;
         gap_d   = '0;
         instr_d = NOP;
      end else if (!q.stall) begin
         case (state_q)
            ST_IDLE:  try_issue = 1'b1;
            ST_ISSUE: begin
               if (NOP_GAP > 0) begin
                  state_d = ST_GAP;
                  gap_d   = GAP_LOAD;
                  instr_d = NOP;
               end else begin
                  try_issue = 1'b1;
               end
            end
            ST_GAP: begin
               if (gap_q == '0) try_issue = 1'b1;
               else             gap_d     = gap_q - GW'(1);
            end
            default: begin
               state_d = ST_IDLE;
               instr_d = NOP;
            end
         endcase
         // shared exit test: take the head if one is waiting, else go quiet
         if (try_issue) begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = ST_ISSUE;
               instr_d = head;
            end else begin
               state_d = ST_IDLE;
               instr_d = NOP;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         gap_q   <= '0;
         instr_q <= NOP;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         instr_q <= instr_d;
      end
   end

   // a stalled ISSUE cycle holds the word but reports it only once, when it moves on
   assign q.issued      = (state_q == ST_ISSUE) && !q.stall;
   assign q.Instruction = instr_q;
   assign q.count       = fifo_count;
   assign q.empty       = fifo_empty;
   assign q.full        = fifo_full;

endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed bench for instr_issue_queue (DEPTH=8, NOP_GAP=4): reset, pacing,
// back-pressure, stall, flush and mid-issue reset with hand-computed values.
module tb_instr_issue_queue;
   import arm_pkg::*;

   localparam int DEPTH   = 8;
   localparam int NOP_GAP = 4;

   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   int          n_chk  = 0;
   int          n_fail = 0;
   int          pulses;
   logic        iss;
   logic [31:0] exp_w;
   logic [31:0] w3 [3];
   logic [31:0] wq [9];

   instr_issue_queue_if #(.DEPTH(DEPTH)) bus();

   instr_issue_queue #(
      .DEPTH   (DEPTH),
      .NOP_GAP (NOP_GAP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .q     (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [31:0] instr, input logic isd);
      chk({tag, ".instr"}, bus.Instruction, instr);
      chk({tag, ".issued"}, 32'(bus.issued), 32'(isd));
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_instr = '0;
      bus.stall    = 1'b0;
      bus.flush    = 1'b0;
      w3[0] = 32'h1111_0001;
      w3[1] = 32'h2222_0002;
      w3[2] = 32'h3333_0003;
      for (int i = 0; i < 9; i++) wq[i] = 32'hC0DE_0000 | 32'(i + 1);

      // reset state
      #2;
      chk_out("rst", NOP, 1'b0);
      chk("rst.count", 32'(bus.count), 0);
      chk("rst.empty", 32'(bus.empty), 1);
      chk("rst.full", 32'(bus.full), 0);
      chk("rst.in_ready", 32'(bus.in_ready), 1);
      step();
      step();

      // single word straight after reset release
      reset        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_instr = 32'hE281_1FFF;
      step();
      bus.in_valid = 1'b0;
      chk("one.count_after_push", 32'(bus.count), 1);
      chk_out("one.push_edge", NOP, 1'b0);
      step();
      chk_out("one.issue", 32'hE281_1FFF, 1'b1);
      chk("one.count_after_pop", 32'(bus.count), 0);
      chk("one.empty", 32'(bus.empty), 1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk_out("one.gap", NOP, 1'b0);
      end
      step();
      chk_out("one.idle", NOP, 1'b0);
      step();
      chk_out("one.idle2", NOP, 1'b0);

      // three words back-to-back: issues 5 cycles apart
      bus.in_valid = 1'b1;
      bus.in_instr = w3[0];
      step();
      chk("b2b.count1", 32'(bus.count), 1);
      bus.in_instr = w3[1];
      step();
      chk_out("b2b.first", w3[0], 1'b1);
      chk("b2b.count2", 32'(bus.count), 1);
      bus.in_instr = w3[2];
      pulses = 1;
      for (int c = 3; c <= 17; c++) begin
         step();
         if (c == 3) bus.in_valid = 1'b0;
         exp_w = (c == 7) ? w3[1] : (c == 12) ? w3[2] : NOP;
         iss   = (c == 7) || (c == 12);
         chk_out("b2b.stream", exp_w, iss);
         if (bus.issued) pulses++;
      end
      chk("b2b.pulses", 32'(pulses), 3);
      chk("b2b.count_end", 32'(bus.count), 0);
      chk("b2b.empty_end", 32'(bus.empty), 1);

      // fill to DEPTH under stall, hold a 9th word until space opens
      bus.stall = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.in_valid = 1'b1;
         bus.in_instr = wq[i];
         step();
      end
      bus.in_instr = wq[8];
      #1;
      chk("full.count", 32'(bus.count), 8);
      chk("full.full", 32'(bus.full), 1);
      chk("full.in_ready", 32'(bus.in_ready), 0);
      chk("full.empty", 32'(bus.empty), 0);
      chk_out("full.stalled", NOP, 1'b0);
      step();
      chk("full.no_drop_push", 32'(bus.count), 8);
      bus.stall = 1'b0;
      step();
      chk_out("full.first", wq[0], 1'b1);
      chk("full.count_after_pop", 32'(bus.count), 7);
      chk("full.in_ready_after_pop", 32'(bus.in_ready), 1);
      step();
      bus.in_valid = 1'b0;
      chk("full.ninth_taken", 32'(bus.count), 8);
      chk_out("full.gap_start", NOP, 1'b0);
      for (int c = 2; c <= 46; c++) begin
         step();
         iss = ((c % 5) == 0) && (c <= 40);
         exp_w = iss ? wq[c / 5] : NOP;
         chk_out("full.order", exp_w, iss);
      end
      chk("full.count_end", 32'(bus.count), 0);
      chk("full.empty_end", 32'(bus.empty), 1);

      // stall 3 cycles during GAP delays the next issue by 3
      bus.in_valid = 1'b1;
      bus.in_instr = 32'hAAAA_0001;
      step();
      bus.in_instr = 32'hBBBB_0002;
      step();
      bus.in_valid = 1'b0;
      chk_out("stall.first", 32'hAAAA_0001, 1'b1);
      step();
      step();
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_out("stall.hold", NOP, 1'b0);
         chk("stall.count", 32'(bus.count), 1);
      end
      bus.stall = 1'b0;
      step();
      chk_out("stall.gap1", NOP, 1'b0);
      step();
      chk_out("stall.gap0", NOP, 1'b0);
      step();
      chk_out("stall.second", 32'hBBBB_0002, 1'b1);
      chk("stall.count_end", 32'(bus.count), 0);
      for (int i = 0; i < 5; i++) step();

      // flush with 5 words queued while in GAP
      bus.in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.in_instr = 32'h5000_0000 | 32'(i);
         step();
      end
      chk("flush.count_before", 32'(bus.count), 5);
      chk_out("flush.in_gap", NOP, 1'b0);
      bus.flush    = 1'b1;
      bus.in_instr = 32'hDEAD_BEEF;
      #1;
      chk("flush.in_ready", 32'(bus.in_ready), 0);
      step();
      chk("flush.count", 32'(bus.count), 0);
      chk("flush.empty", 32'(bus.empty), 1);
      chk_out("flush.after", NOP, 1'b0);
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      step();
      chk_out("flush.idle", NOP, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_instr = 32'h7777_0007;
      step();
      bus.in_valid = 1'b0;
      chk("flush.repush_count", 32'(bus.count), 1);
      step();
      chk_out("flush.repush_issue", 32'h7777_0007, 1'b1);
      for (int i = 0; i < 5; i++) step();

      // async reset mid-ISSUE with 2 words still queued
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.in_instr = 32'h9000_0000 | 32'(i);
         step();
      end
      bus.in_valid = 1'b0;
      bus.stall    = 1'b0;
      step();
      chk_out("rstmid.issue", 32'h9000_0000, 1'b1);
      chk("rstmid.count_before", 32'(bus.count), 2);
      #2;
      reset = 1'b0;
      #1;
      chk_out("rstmid.async", NOP, 1'b0);
      chk("rstmid.count", 32'(bus.count), 0);
      chk("rstmid.empty", 32'(bus.empty), 1);
      chk("rstmid.full", 32'(bus.full), 0);
      step();
      step();
      reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         chk_out("rstmid.after", NOP, 1'b0);
         chk("rstmid.after_count", 32'(bus.count), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
